// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the parity arbiter:
//   state_t  - arbiter FSM states (IDLE, ACC, DONE)
//   NUM_REQ  - number of requesters competing for the accumulator
//   rr_pick  - round-robin grant selection between the two requesters
// ---------------------------------------------------------------------------
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_REQ = 2;

    // Both requesting: hand the grant to the one not served last.
    // Only one requesting: it wins regardless of history.
    function automatic logic rr_pick(input logic [NUM_REQ-1:0] valid,
                                     input logic               last_served);
        if (valid == 2'b11) begin
            return ~last_served;
        end
        return valid[1];
    endfunction

endpackage

// File: rtl/xor4.sv
// ---------------------------------------------------------------------------
// xor4
// XOR reduction of one 4-bit nibble.
// Ports:
//   data   - input nibble
//   parity - 1 when data holds an odd number of ones
// ---------------------------------------------------------------------------
module xor4 (
    input  logic [3:0] data,
    output logic       parity
);

    assign parity = ^data;

endmodule

// File: rtl/parity_arb.sv
// ---------------------------------------------------------------------------
// parity_arb
// Two-requester round-robin arbiter that grants one packet at a time and
// accumulates the XOR parity of every accepted data nibble of that packet.
// A packet ends on req_last or after MAX_BEATS beats (truncation); the result
// is then presented on a registered valid/ready output until consumed.
//
// Parameters:
//   MAX_BEATS  - beats per packet before forced termination (1..15)
// Ports:
//   clk        - rising-edge clock
//   reset_n    - synchronous active-low reset
//   req_valid  - per-requester beat valid
//   req_data0  - requester 0 data nibble
//   req_data1  - requester 1 data nibble
//   req_last   - per-requester last-beat flag
//   req_ready  - per-requester beat accept (one-hot or zero)
//   res_valid  - result available
//   res_ready  - result consumer accept
//   res_parity - XOR of all bits of the packet's accepted beats
//   res_id     - requester that owned the packet
//   res_trunc  - packet ended by MAX_BEATS rather than req_last
//   res_beats  - accepted beat count (only with PARITY_ARB_BEATS_EN)
// Build option:
//   PARITY_ARB_BEATS_EN - adds the res_beats output
// ---------------------------------------------------------------------------
module parity_arb
    import parity_pkg::*;
#(
    parameter int MAX_BEATS = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [3:0]         req_data0,
    input  logic [3:0]         req_data1,
    input  logic [NUM_REQ-1:0] req_last,
    output logic [NUM_REQ-1:0] req_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_parity,
    output logic               res_id,
`ifdef PARITY_ARB_BEATS_EN
    output logic               res_trunc,
    output logic [3:0]         res_beats
`else
    output logic               res_trunc
`endif
);

    localparam logic [3:0] MAX_BEATS_4 = 4'(MAX_BEATS);

    state_t     state_reg, state_next;
    logic       grant_reg, grant_next;
    logic       last_served_reg, last_served_next;
    logic       acc_reg, acc_next;
    logic [3:0] count_reg, count_next;

    logic       res_valid_reg, res_valid_next;
    logic       res_parity_reg, res_parity_next;
    logic       res_id_reg, res_id_next;
    logic       res_trunc_reg, res_trunc_next;
`ifdef PARITY_ARB_BEATS_EN
    logic [3:0] res_beats_reg, res_beats_next;
`endif

    logic [3:0] beat_data;
    logic       beat_parity;
    logic       beat_fire;
    logic       beat_last;
    logic [3:0] count_inc;
    logic       at_max;

    // Ready depends only on state and grant, so it never combinationally
    // follows the requester's own valid.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == ACC) && (grant_reg == 1'(gi));
        end
    endgenerate

    assign beat_data = grant_reg ? req_data1 : req_data0;

    xor4 u_xor4 (
        .data   (beat_data),
        .parity (beat_parity)
    );

    assign beat_fire = (state_reg == ACC) && req_valid[grant_reg];
    assign beat_last = req_last[grant_reg];
    assign count_inc = count_reg + 4'd1;
    assign at_max    = (count_inc == MAX_BEATS_4);

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        last_served_next = last_served_reg;
        acc_next         = acc_reg;
        count_next       = count_reg;
        res_valid_next   = res_valid_reg;
        res_parity_next  = res_parity_reg;
        res_id_next      = res_id_reg;
        res_trunc_next   = res_trunc_reg;
`ifdef PARITY_ARB_BEATS_EN
        res_beats_next   = res_beats_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (|req_valid) begin
                    grant_next = rr_pick(req_valid, last_served_reg);
                    state_next = ACC;
                end
            end

            ACC: begin
                if (beat_fire) begin
                    acc_next   = acc_reg ^ beat_parity;
                    count_next = count_inc;
                    if (beat_last || at_max) begin
                        state_next      = DONE;
                        res_valid_next  = 1'b1;
                        res_parity_next = acc_reg ^ beat_parity;
                        res_id_next     = grant_reg;
                        // A last flag on the MAX_BEATS beat is a normal end.
                        res_trunc_next  = ~beat_last;
`ifdef PARITY_ARB_BEATS_EN
                        res_beats_next  = count_inc;
`endif
                        // Result registers now hold the packet; start the
                        // next packet from a clean accumulator.
                        acc_next        = 1'b0;
                        count_next      = 4'd0;
                    end
                end
            end

            DONE: begin
                if (res_ready) begin
                    state_next       = IDLE;
                    res_valid_next   = 1'b0;
                    last_served_next = res_id_reg;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            grant_reg       <= 1'b0;
            // Requester 0 wins the first tie after reset.
            last_served_reg <= 1'b1;
            acc_reg         <= 1'b0;
            count_reg       <= 4'd0;
            res_valid_reg   <= 1'b0;
            res_parity_reg  <= 1'b0;
            res_id_reg      <= 1'b0;
            res_trunc_reg   <= 1'b0;
`ifdef PARITY_ARB_BEATS_EN
            res_beats_reg   <= 4'd0;
`endif
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            last_served_reg <= last_served_next;
            acc_reg         <= acc_next;
            count_reg       <= count_next;
            res_valid_reg   <= res_valid_next;
            res_parity_reg  <= res_parity_next;
            res_id_reg      <= res_id_next;
            res_trunc_reg   <= res_trunc_next;
`ifdef PARITY_ARB_BEATS_EN
            res_beats_reg   <= res_beats_next;
`endif
        end
    end

    assign res_valid  = res_valid_reg;
    assign res_parity = res_parity_reg;
    assign res_id     = res_id_reg;
    assign res_trunc  = res_trunc_reg;
`ifdef PARITY_ARB_BEATS_EN
    assign res_beats  = res_beats_reg;
`endif

endmodule
